sr_coherence_detector: RTL and testbench

SR_COHERENCE_DETECTOR -- requirements
Module: sr_coherence_detector

---
 rtl/sr_coh_pkg.sv | 16 +
 rtl/sr_leaky_integrator.sv | 34 +++
 rtl/sr_coherence_detector.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_sr_coherence_detector.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/sr_coh_pkg.sv
// Shared constants and beta-FSM state encodings for the SR coherence detector.
package sr_coh_pkg;

    localparam int ONE_Q14     = 16384;
    localparam int MAG_SHIFT_A = 2;
    localparam int MAG_SHIFT_B = 3;

    localparam logic [15:0] HOLD_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        BETA_BUSY    = 2'd0,
        BETA_PENDING = 2'd1,
        BETA_QUIET   = 2'd2
    } beta_state_e;

endpackage

// File: rtl/sr_leaky_integrator.sv
// First-order leaky averager: acc += x - acc>>>SHIFT, average = acc>>>SHIFT.
module sr_leaky_integrator #(
    parameter int WIDTH = 18,
    parameter int SHIFT = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_clk_en,
    input  logic signed [WIDTH-1:0] i_x,
    output logic signed [WIDTH-1:0] o_avg
);

    localparam int ACC_W = WIDTH + SHIFT;

    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] w_x_ext;
    logic signed [ACC_W-1:0] w_leak;

    assign w_x_ext = ACC_W'(i_x);
    assign w_leak  = r_acc >>> SHIFT;
    assign o_avg   = w_leak[WIDTH-1:0];

    // accumulator update, gated by the sample strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_clk_en) begin
            r_acc <= r_acc + w_x_ext - w_leak;
        end else begin
            r_acc <= r_acc;
        end
    end

endmodule

// File: rtl/sr_coherence_detector.sv
// Phase-locking-value estimator between SR reference and oscillator, plus a beta-quiet FSM.
// Build option: SR_COH_BETA_HYST_EN enables the thresh_hi hysteresis for leaving QUIET.
module sr_coherence_detector
    import sr_coh_pkg::*;
#(
    parameter int WIDTH      = 18,
    parameter int FRAC       = 14,
    parameter int COH_SHIFT  = 8,
    parameter int BETA_SHIFT = 6,
    parameter int WARMUP     = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clk_en,
    input  logic signed [WIDTH-1:0] ref_cos,
    input  logic signed [WIDTH-1:0] ref_sin,
    input  logic signed [WIDTH-1:0] osc_cos,
    input  logic signed [WIDTH-1:0] osc_sin,
    input  logic signed [WIDTH-1:0] beta_amp,
    input  logic signed [WIDTH-1:0] beta_thresh_lo,
    input  logic signed [WIDTH-1:0] beta_thresh_hi,
    input  logic        [15:0]      quiet_hold,
    output logic signed [WIDTH-1:0] coherence_out,
    output logic                    coherence_valid,
    output logic                    beta_quiet,
    output logic        [1:0]       beta_state
);

    localparam int PROD_W = 2 * WIDTH + 1;
    localparam int CNT_W  = $clog2(WARMUP + 2);

    localparam logic signed [PROD_W-1:0] L_POS_FULL = PROD_W'(ONE_Q14);
    localparam logic signed [PROD_W-1:0] L_NEG_FULL = -L_POS_FULL;
    localparam logic signed [WIDTH-1:0]  L_POS      = WIDTH'(ONE_Q14);
    localparam logic signed [WIDTH-1:0]  L_NEG      = -L_POS;
    localparam logic        [WIDTH:0]    L_ONE_MAG  = (WIDTH + 1)'(ONE_Q14);
    localparam logic        [CNT_W-1:0]  L_WARMUP   = CNT_W'(WARMUP);

    function automatic logic signed [WIDTH-1:0] sat_q14(input logic signed [PROD_W-1:0] v);
        if (v > L_POS_FULL) begin
            return L_POS;
        end else if (v < L_NEG_FULL) begin
            return L_NEG;
        end else begin
            return v[WIDTH-1:0];
        end
    endfunction

    // Stage 1: complex product ref * conj(osc)
    logic signed [PROD_W-1:0] w_re_full;
    logic signed [PROD_W-1:0] w_im_full;
    logic signed [PROD_W-1:0] w_re_shift;
    logic signed [PROD_W-1:0] w_im_shift;
    logic signed [WIDTH-1:0]  r_re;
    logic signed [WIDTH-1:0]  r_im;

    assign w_re_full  = PROD_W'(ref_cos) * PROD_W'(osc_cos) + PROD_W'(ref_sin) * PROD_W'(osc_sin);
    assign w_im_full  = PROD_W'(ref_sin) * PROD_W'(osc_cos) - PROD_W'(ref_cos) * PROD_W'(osc_sin);
    assign w_re_shift = w_re_full >>> FRAC;
    assign w_im_shift = w_im_full >>> FRAC;

    // stage-1 product registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_re <= '0;
            r_im <= '0;
        end else if (clk_en) begin
            r_re <= sat_q14(w_re_shift);
            r_im <= sat_q14(w_im_shift);
        end else begin
            r_re <= r_re;
            r_im <= r_im;
        end
    end

    // Stage 2: leaky averages of the product and of the beta envelope
    logic signed [WIDTH-1:0] w_re_avg;
    logic signed [WIDTH-1:0] w_im_avg;
    logic signed [WIDTH-1:0] w_beta_clamp;
    logic signed [WIDTH-1:0] w_beta_avg;

    sr_leaky_integrator #(.WIDTH(WIDTH), .SHIFT(COH_SHIFT)) u_int_re (
        .clk      (clk),
        .rst      (rst),
        .i_clk_en (clk_en),
        .i_x      (r_re),
        .o_avg    (w_re_avg)
    );

    sr_leaky_integrator #(.WIDTH(WIDTH), .SHIFT(COH_SHIFT)) u_int_im (
        .clk      (clk),
        .rst      (rst),
        .i_clk_en (clk_en),
        .i_x      (r_im),
        .o_avg    (w_im_avg)
    );

    sr_leaky_integrator #(.WIDTH(WIDTH), .SHIFT(BETA_SHIFT)) u_int_beta (
        .clk      (clk),
        .rst      (rst),
        .i_clk_en (clk_en),
        .i_x      (w_beta_clamp),
        .o_avg    (w_beta_avg)
    );

    // negative amplitudes carry no beta power
    always_comb begin
        if (beta_amp[WIDTH-1]) begin
            w_beta_clamp = '0;
        end else begin
            w_beta_clamp = beta_amp;
        end
    end

    // Stage 3: alpha-max-beta-min magnitude with (1/4 + 1/8) minor weight
    logic [WIDTH-1:0]        w_abs_re;
    logic [WIDTH-1:0]        w_abs_im;
    logic [WIDTH-1:0]        w_max;
    logic [WIDTH-1:0]        w_min;
    logic [WIDTH:0]          w_mag_sum;
    logic signed [WIDTH-1:0] w_mag_sat;

    always_comb begin
        w_abs_re = '0;
        w_abs_im = '0;
        w_max    = '0;
        w_min    = '0;
        if (w_re_avg[WIDTH-1]) begin
            w_abs_re = -w_re_avg;
        end else begin
            w_abs_re = w_re_avg;
        end
        if (w_im_avg[WIDTH-1]) begin
            w_abs_im = -w_im_avg;
        end else begin
            w_abs_im = w_im_avg;
        end
        if (w_abs_re >= w_abs_im) begin
            w_max = w_abs_re;
            w_min = w_abs_im;
        end else begin
            w_max = w_abs_im;
            w_min = w_abs_re;
        end
        w_mag_sum = {1'b0, w_max} + ({1'b0, w_min} >> MAG_SHIFT_A) + ({1'b0, w_min} >> MAG_SHIFT_B);
        if (w_mag_sum > L_ONE_MAG) begin
            w_mag_sat = L_POS;
        end else begin
            w_mag_sat = w_mag_sum[WIDTH-1:0];
        end
    end

    logic [CNT_W-1:0]        r_warm_cnt;
    logic [CNT_W-1:0]        w_warm_next;
    logic signed [WIDTH-1:0] r_coh;
    logic                    r_valid;

    // warmup count saturates at WARMUP
    always_comb begin
        if (r_warm_cnt >= L_WARMUP) begin
            w_warm_next = L_WARMUP;
        end else begin
            w_warm_next = r_warm_cnt + CNT_W'(1);
        end
    end

    // output stage: magnitude is masked to zero until warmup completes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_warm_cnt <= '0;
            r_valid    <= 1'b0;
            r_coh      <= '0;
        end else if (clk_en) begin
            r_warm_cnt <= w_warm_next;
            r_valid    <= (w_warm_next == L_WARMUP);
            if (w_warm_next == L_WARMUP) begin
                r_coh <= w_mag_sat;
            end else begin
                r_coh <= '0;
            end
        end else begin
            r_warm_cnt <= r_warm_cnt;
            r_valid    <= r_valid;
            r_coh      <= r_coh;
        end
    end

    assign coherence_out   = r_coh;
    assign coherence_valid = r_valid;

    // Beta-quiet FSM
    logic                    w_below_lo;
    logic                    w_quiet_exit;
    logic signed [WIDTH-1:0] w_exit_thr;
    logic [15:0]             w_hold_inc;
    logic                    w_unused_thresh_hi;
    beta_state_e             r_state;
    logic [15:0]             r_hold;
    logic                    r_quiet;

    always_comb begin
        w_below_lo = (w_beta_avg < beta_thresh_lo);
`ifdef SR_COH_BETA_HYST_EN
        w_unused_thresh_hi = 1'b0;
        if (beta_thresh_hi > beta_thresh_lo) begin
            w_exit_thr = beta_thresh_hi;
        end else begin
            w_exit_thr = beta_thresh_lo;
        end
        w_quiet_exit = (w_beta_avg > w_exit_thr);
`else
        w_unused_thresh_hi = ^beta_thresh_hi;
        w_exit_thr         = beta_thresh_lo;
        w_quiet_exit       = (w_beta_avg >= w_exit_thr);
`endif
        if (r_hold == HOLD_MAX) begin
            w_hold_inc = r_hold;
        end else begin
            w_hold_inc = r_hold + 16'd1;
        end
    end

    // state, hold counter and quiet flag advance together on each sample
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= BETA_BUSY;
            r_hold  <= 16'd0;
            r_quiet <= 1'b0;
        end else if (clk_en) begin
            case (r_state)
                BETA_BUSY: begin
                    r_quiet <= 1'b0;
                    if (w_below_lo) begin
                        r_state <= BETA_PENDING;
                        r_hold  <= 16'd0;
                    end else begin
                        r_state <= BETA_BUSY;
                    end
                end
                BETA_PENDING: begin
                    if (!w_below_lo) begin
                        r_state <= BETA_BUSY;
                        r_quiet <= 1'b0;
                    end else begin
                        r_hold <= w_hold_inc;
                        if (r_hold >= quiet_hold) begin
                            r_state <= BETA_QUIET;
                            r_quiet <= 1'b1;
                        end else begin
                            r_state <= BETA_PENDING;
                            r_quiet <= 1'b0;
                        end
                    end
                end
                BETA_QUIET: begin
                    if (w_quiet_exit) begin
                        r_state <= BETA_BUSY;
                        r_quiet <= 1'b0;
                    end else begin
                        r_state <= BETA_QUIET;
                        r_quiet <= 1'b1;
                    end
                end
                default: begin
                    r_state <= BETA_BUSY;
                    r_hold  <= 16'd0;
                    r_quiet <= 1'b0;
                end
            endcase
        end else begin
            r_state <= r_state;
            r_hold  <= r_hold;
            r_quiet <= r_quiet;
        end
    end

    assign beta_quiet = r_quiet;
    assign beta_state = r_state;

endmodule

// File: tb/tb_sr_coherence_detector.sv
// Self-checking bench: random and directed stimulus against an integer reference model.
module tb_sr_coherence_detector;

    localparam int WIDTH      = 18;
    localparam int FRAC       = 14;
    localparam int COH_SHIFT  = 8;
    localparam int BETA_SHIFT = 6;
    localparam int WARMUP     = 1024;
    localparam longint ONE    = 64'sd16384;
`ifdef SR_COH_BETA_HYST_EN
    localparam int HYST = 1;
`else
    localparam int HYST = 0;
`endif

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    clk_en;
    logic signed [WIDTH-1:0] ref_cos, ref_sin, osc_cos, osc_sin;
    logic signed [WIDTH-1:0] beta_amp, beta_thresh_lo, beta_thresh_hi;
    logic        [15:0]      quiet_hold;
    logic signed [WIDTH-1:0] coherence_out;
    logic                    coherence_valid;
    logic                    beta_quiet;
    logic        [1:0]       beta_state;

    int n_compared   = 0;
    int n_mismatched = 0;

    longint m_re, m_im, m_acc_re, m_acc_im, m_acc_b, m_out;
    int     m_cnt, m_valid, m_state, m_hold, m_quiet;
    int     sample_idx;

    sr_coherence_detector #(
        .WIDTH(WIDTH), .FRAC(FRAC), .COH_SHIFT(COH_SHIFT),
        .BETA_SHIFT(BETA_SHIFT), .WARMUP(WARMUP)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .clk_en          (clk_en),
        .ref_cos         (ref_cos),
        .ref_sin         (ref_sin),
        .osc_cos         (osc_cos),
        .osc_sin         (osc_sin),
        .beta_amp        (beta_amp),
        .beta_thresh_lo  (beta_thresh_lo),
        .beta_thresh_hi  (beta_thresh_hi),
        .quiet_hold      (quiet_hold),
        .coherence_out   (coherence_out),
        .coherence_valid (coherence_valid),
        .beta_quiet      (beta_quiet),
        .beta_state      (beta_state)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_compared++;
        if (got != exp) begin
            n_mismatched++;
            $display("FAIL %s at sample %0d: got %0d, expected %0d", tag, sample_idx, got, exp);
        end
    endtask

    function automatic longint sat16k(input longint v);
        if (v > ONE) return ONE;
        if (v < -ONE) return -ONE;
        return v;
    endfunction

    function automatic longint mag_est(input longint x, input longint y);
        longint a  = (x < 0) ? -x : x;
        longint b  = (y < 0) ? -y : y;
        longint mx = (a > b) ? a : b;
        longint mn = (a > b) ? b : a;
        longint m  = mx + (mn >>> 2) + (mn >>> 3);
        return (m > ONE) ? ONE : m;
    endfunction

    task automatic model_reset();
        m_re = 0; m_im = 0; m_acc_re = 0; m_acc_im = 0; m_acc_b = 0; m_out = 0;
        m_cnt = 0; m_valid = 0; m_state = 0; m_hold = 0; m_quiet = 0;
    endtask

    // One accepted sample: each stage consumes the previous value of the one before it.
    task automatic model_step();
        longint avg_re = m_acc_re >>> COH_SHIFT;
        longint avg_im = m_acc_im >>> COH_SHIFT;
        longint bavg   = m_acc_b >>> BETA_SHIFT;
        longint rc = longint'(ref_cos), rs = longint'(ref_sin);
        longint oc = longint'(osc_cos), os = longint'(osc_sin);
        longint lo = longint'(beta_thresh_lo), hi = longint'(beta_thresh_hi);
        longint bx = (beta_amp < 0) ? 64'sd0 : longint'(beta_amp);
        longint exit_thr = (HYST != 0 && hi > lo) ? hi : lo;
        m_cnt   = (m_cnt >= WARMUP) ? WARMUP : m_cnt + 1;
        m_valid = (m_cnt >= WARMUP) ? 1 : 0;
        m_out   = (m_valid != 0) ? mag_est(avg_re, avg_im) : 64'sd0;
        m_acc_re = m_acc_re + m_re - avg_re;
        m_acc_im = m_acc_im + m_im - avg_im;
        m_re = sat16k((rc * oc + rs * os) >>> FRAC);
        m_im = sat16k((rs * oc - rc * os) >>> FRAC);
        case (m_state)
            0: if (bavg < lo) begin m_state = 1; m_hold = 0; end
            1: begin
                if (bavg >= lo) m_state = 0;
                else begin
                    if (m_hold >= int'(quiet_hold)) m_state = 2;
                    if (m_hold < 65535) m_hold++;
                end
            end
            default: begin
                if ((HYST != 0) ? (bavg > exit_thr) : (bavg >= lo)) m_state = 0;
            end
        endcase
        m_quiet = (m_state == 2) ? 1 : 0;
        m_acc_b = m_acc_b + bx - bavg;
    endtask

    task automatic do_cycle(input bit en, input bit do_rst);
        @(negedge clk);
        clk_en = en;
        rst    = do_rst;
        @(posedge clk);
        if (do_rst) model_reset();
        else if (en) model_step();
        #1;
        if (do_rst) sample_idx = 0;
        else if (en) sample_idx++;
        check_eq("coh_out",   longint'(coherence_out),   m_out);
        check_eq("coh_valid", longint'(coherence_valid), longint'(m_valid));
        check_eq("beta_quiet", longint'(beta_quiet),     longint'(m_quiet));
        check_eq("beta_state", longint'(beta_state),     longint'(m_state));
    endtask

    function automatic logic signed [WIDTH-1:0] rnd(input int lo_v, input int hi_v);
        int r = int'($urandom_range(32'(hi_v - lo_v), 32'd0)) + lo_v;
        return WIDTH'(r);
    endfunction

    initial begin
        int rise_idx, pend_idx, quiet_idx;
        rst = 1'b1; clk_en = 1'b0;
        ref_cos = '0; ref_sin = '0; osc_cos = '0; osc_sin = '0;
        beta_amp = '0; beta_thresh_lo = '0; beta_thresh_hi = '0; quiet_hold = 16'd0;
        sample_idx = 0;
        model_reset();
        do_cycle(1'b1, 1'b1);
        do_cycle(1'b1, 1'b1);
        check_eq("rst_coh_out", longint'(coherence_out), 64'sd0);
        check_eq("rst_valid", longint'(coherence_valid), 64'sd0);
        check_eq("rst_quiet", longint'(beta_quiet), 64'sd0);
        check_eq("rst_state", longint'(beta_state), 64'sd0);

        // Locked phasors with beta settling below the entry threshold
        ref_cos = 18'sd16384; ref_sin = 18'sd0; osc_cos = 18'sd16384; osc_sin = 18'sd0;
        beta_amp = 18'sd2000; beta_thresh_lo = 18'sd3000; beta_thresh_hi = 18'sd5000;
        quiet_hold = 16'd100;
        rise_idx = -1; pend_idx = -1; quiet_idx = -1;
        for (int i = 0; i < 2000; i++) begin
            do_cycle(1'b1, 1'b0);
            if (coherence_valid && rise_idx < 0) rise_idx = sample_idx;
            if (beta_state == 2'd1 && pend_idx < 0) pend_idx = sample_idx;
            if (beta_quiet && quiet_idx < 0) quiet_idx = sample_idx;
        end
        check_eq("valid_rise", longint'(rise_idx), 64'sd1024);
        check_eq("coh_lock_ge16000", (coherence_out >= 18'sd16000) ? 64'sd1 : 64'sd0, 64'sd1);
        check_eq("quiet_after_hold", longint'(quiet_idx - pend_idx), 64'sd101);

        // 90-degree offset; beta raised above the entry but below the exit-hi threshold
        osc_cos = 18'sd0; osc_sin = 18'sd16384; beta_amp = 18'sd4000;
        for (int i = 0; i < 2000; i++) do_cycle(1'b1, 1'b0);
        check_eq("mag_90deg_ge15900", (coherence_out >= 18'sd15900) ? 64'sd1 : 64'sd0, 64'sd1);
        check_eq("quiet_at_4000", longint'(beta_quiet), longint'(HYST));

        // Random phasors, beta and thresholds with sparse strobes
        for (int i = 0; i < 1500; i++) begin
            if (i % 300 == 0) begin
                beta_thresh_lo = rnd(0, 8000);
                beta_thresh_hi = rnd(0, 8000);
                quiet_hold     = 16'($urandom_range(20, 0));
            end
            ref_cos = rnd(-20000, 20000); ref_sin = rnd(-20000, 20000);
            osc_cos = rnd(-20000, 20000); osc_sin = rnd(-20000, 20000);
            beta_amp = rnd(-3000, 12000);
            do_cycle(($urandom_range(3, 0) != 0), 1'b0);
        end

        // Mid-run reset, strobe held low, then warmup restarts
        ref_cos = 18'sd16384; ref_sin = 18'sd0; osc_cos = 18'sd16384; osc_sin = 18'sd0;
        beta_amp = 18'sd2000;
        do_cycle(1'b1, 1'b1);
        check_eq("rst2_coh_out", longint'(coherence_out), 64'sd0);
        check_eq("rst2_valid", longint'(coherence_valid), 64'sd0);
        check_eq("rst2_quiet", longint'(beta_quiet), 64'sd0);
        check_eq("rst2_state", longint'(beta_state), 64'sd0);
        for (int i = 0; i < 10; i++) begin
            beta_amp = rnd(0, 9000);
            do_cycle(1'b0, 1'b0);
        end
        check_eq("frozen_state", longint'(beta_state), 64'sd0);
        beta_amp = 18'sd2000;
        rise_idx = -1;
        for (int i = 0; i < 1100; i++) begin
            do_cycle(1'b1, 1'b0);
            if (coherence_valid && rise_idx < 0) rise_idx = sample_idx;
        end
        check_eq("valid_rerise", longint'(rise_idx), 64'sd1024);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
